// File: rtl/mem_stage.sv
// Memory stage: launches one data-bus access at a time, lane-places stores,
// formats loads and registers the writeback for the next stage.
//
// state  | meaning
// IDLE   | no bus access outstanding
// ACCESS | request held on the bus, waiting for dmem_ready
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  output logic            mem_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic [XLEN-1:0] wb_data,
  output logic            mem_exc
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state, state_nxt;
  logic            is_mem, bad_f3, misaligned, exc;
  logic            accept, launch, complete, imm;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;
  logic [2:0]      acc_f3;
  logic [1:0]      acc_off;
  logic [XLEN-1:0] acc_full;
  logic [4:0]      acc_rd;
  logic            acc_rw;
  logic            pend_valid, pend_rw, pend_exc;
  logic [4:0]      pend_rd;
  logic [XLEN-1:0] pend_data;

  assign is_mem   = mem_read | mem_write;
  assign mem_stall = (state == ACCESS) & ~dmem_ready;
  assign accept   = ex_valid & ~mem_stall;
  assign complete = (state == ACCESS) & dmem_ready;

  always_comb begin
    bad_f3     = mem_write ? (funct3 > 3'b010) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misaligned = (funct3[1:0] == 2'b01 && alu_result[0]) ||
                 (funct3[1:0] == 2'b10 && alu_result[1:0] != 2'b00);
    exc        = is_mem & ((mem_read & mem_write) | bad_f3 | misaligned);
    launch     = accept & is_mem & ~exc;
    imm        = accept & ~launch;
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << alu_result[1:0];
        st_wdata = {(XLEN/8){store_data[7:0]}};
      end
      2'b01: begin
        st_be    = alu_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {(XLEN/16){store_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = store_data;
      end
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata[{acc_off, 3'b000} +: 8];
    ld_half = dmem_rdata[{acc_off[1], 4'b0000} +: 16];
    case (acc_f3)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = ACCESS;
      ACCESS:  if (dmem_ready) state_nxt = launch ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dmem_req = (state == ACCESS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= 4'b0000;
      acc_f3     <= 3'b000;
      acc_off    <= 2'b00;
      acc_full   <= '0;
      acc_rd     <= 5'd0;
      acc_rw     <= 1'b0;
    end else if (launch) begin
      dmem_we    <= mem_write;
      dmem_addr  <= {alu_result[XLEN-1:2], 2'b00};
      dmem_wdata <= mem_write ? st_wdata : '0;
      dmem_be    <= st_be;
      acc_f3     <= funct3;
      acc_off    <= alu_result[1:0];
      acc_full   <= alu_result;
      acc_rd     <= rd;
      acc_rw     <= reg_write & mem_read;
    end
  end

  // A non-memory op accepted in the same cycle a load/store completes is parked
  // one cycle in pend_* so both writebacks leave in program order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      mem_exc      <= 1'b0;
      pend_valid   <= 1'b0;
      pend_rd      <= 5'd0;
      pend_rw      <= 1'b0;
      pend_data    <= '0;
      pend_exc     <= 1'b0;
    end else begin
      wb_valid   <= complete | pend_valid | imm;
      pend_valid <= (complete | pend_valid) & imm;
      if (complete) begin
        wb_rd        <= acc_rd;
        wb_reg_write <= ~dmem_we & acc_rw;
        wb_data      <= dmem_we ? acc_full : ld_data;
        mem_exc      <= 1'b0;
      end else if (pend_valid) begin
        wb_rd        <= pend_rd;
        wb_reg_write <= pend_rw;
        wb_data      <= pend_data;
        mem_exc      <= pend_exc;
      end else if (imm) begin
        wb_rd        <= rd;
        wb_reg_write <= reg_write & ~exc;
        wb_data      <= alu_result;
        mem_exc      <= exc;
      end
      if (imm) begin
        pend_rd   <= rd;
        pend_rw   <= reg_write & ~exc;
        pend_data <= alu_result;
        pend_exc  <= exc;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios then random traffic against an
// in-order writeback queue and a single outstanding-access model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] alu_result = '0, store_data = '0;
  logic [4:0]  rd = 5'd0;
  logic        reg_write = 1'b0;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_reg_write, mem_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .alu_result(alu_result),
    .store_data(store_data), .rd(rd), .reg_write(reg_write),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .mem_exc(mem_exc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        exc;
  } wb_t;

  wb_t exp_q[$];
  bit          busy = 0;
  logic [31:0] cur_full, cur_wdata;
  logic [3:0]  cur_be;
  logic [2:0]  cur_f3;
  logic [4:0]  cur_rd;
  logic        cur_we, cur_rw;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input bit v, input bit r, input bit w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] d, input bit rw);
    ex_valid = v; mem_read = r; mem_write = w; funct3 = f;
    alu_result = a; store_data = sd; rd = d; reg_write = rw;
  endtask

  function automatic bit model_exc(bit r, bit w, logic [2:0] f, logic [31:0] a);
    int size;
    if (r && w) return 1;
    if (w && f > 3'd2) return 1;
    if (r && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1;
    size = 1 << f[1:0];
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f, logic [31:0] a, logic [31:0] w);
    logic [31:0] v, b, h;
    v = w >> (8 * (a % 4));
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic rand_cycle(input bit quiet);
    wb_t e;
    bit  stall_exp;
    int  k;
    if (wb_valid) begin
      check_eq("wb_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("wb_data", wb_data, e.data);
        check_eq("wb_reg_write", wb_reg_write, e.rw);
        check_eq("mem_exc", mem_exc, e.exc);
        if (!e.exc) check_eq("wb_rd", wb_rd, e.rd);
      end
    end
    check_eq("dmem_req", dmem_req, busy);
    if (busy) begin
      check_eq("dmem_addr", dmem_addr, cur_full & ~32'h3);
      check_eq("dmem_we", dmem_we, cur_we);
      if (cur_we) begin
        check_eq("dmem_be", dmem_be, cur_be);
        check_eq("dmem_wdata", dmem_wdata, cur_wdata);
      end
    end
    k = $urandom_range(0, 9);
    mem_read   = (k <= 3) || (k == 7);
    mem_write  = (k >= 4 && k <= 7);
    if ($urandom_range(0, 7) == 0) funct3 = 3'($urandom);
    else if (mem_write) funct3 = 3'($urandom_range(0, 2));
    else begin
      k = $urandom_range(0, 4);
      funct3 = (k > 2) ? 3'(k + 1) : 3'(k);
    end
    alu_result = $urandom;
    if ($urandom_range(0, 3) != 0) alu_result = alu_result & ~((32'd1 << funct3[1:0]) - 1);
    store_data = $urandom;
    rd         = 5'($urandom);
    reg_write  = 1'($urandom);
    dmem_rdata = $urandom;
    ex_valid   = quiet ? 1'b0 : ($urandom_range(0, 3) != 0);
    dmem_ready = quiet ? 1'b1 : ($urandom_range(0, 2) != 0);
    #1;
    stall_exp = busy && !dmem_ready;
    check_eq("mem_stall", mem_stall, stall_exp);
    if (busy && dmem_ready) begin
      if (cur_we) exp_q.push_back('{cur_full, cur_rd, 1'b0, 1'b0});
      else        exp_q.push_back('{model_load(cur_f3, cur_full, dmem_rdata), cur_rd, cur_rw, 1'b0});
      busy = 0;
    end
    if (ex_valid && !stall_exp) begin
      if (!mem_read && !mem_write)
        exp_q.push_back('{alu_result, rd, reg_write, 1'b0});
      else if (model_exc(mem_read, mem_write, funct3, alu_result))
        exp_q.push_back('{alu_result, rd, 1'b0, 1'b1});
      else begin
        busy     = 1;
        cur_full = alu_result;
        cur_we   = mem_write;
        cur_f3   = funct3;
        cur_rd   = rd;
        cur_rw   = reg_write;
        case (funct3[1:0])
          2'd0: begin
            cur_be    = 4'(1 << (alu_result % 4));
            cur_wdata = (store_data & 32'hFF) * 32'h0101_0101;
          end
          2'd1: begin
            cur_be    = (alu_result % 4 == 2) ? 4'hC : 4'h3;
            cur_wdata = (store_data & 32'hFFFF) * 32'h0001_0001;
          end
          default: begin
            cur_be    = 4'hF;
            cur_wdata = store_data;
          end
        endcase
      end
    end
    tick();
  endtask

  initial begin
    @(negedge clk);
    check_eq("rst_wb_valid", wb_valid, 0);
    check_eq("rst_dmem_req", dmem_req, 0);
    check_eq("rst_mem_stall", mem_stall, 0);
    check_eq("rst_dmem_be", dmem_be, 0);
    check_eq("rst_dmem_addr", dmem_addr, 0);
    check_eq("rst_wb_data", wb_data, 0);
    check_eq("rst_mem_exc", mem_exc, 0);
    rst = 1'b0;

    // ALU op, latency 1
    set_op(1, 0, 0, 3'd0, 32'h0000_1234, 0, 5'd5, 1);
    tick();
    set_op(0, 0, 0, 3'd0, 0, 0, 5'd0, 0);
    check_eq("alu_wb_valid", wb_valid, 1);
    check_eq("alu_wb_data", wb_data, 32'h0000_1234);
    check_eq("alu_wb_rd", wb_rd, 5);
    check_eq("alu_wb_rw", wb_reg_write, 1);
    check_eq("alu_no_req", dmem_req, 0);

    // LB with three wait cycles, then LBU
    set_op(1, 1, 0, 3'd0, 32'h103, 0, 5'd9, 1);
    dmem_ready = 1'b0;
    tick();
    set_op(0, 0, 0, 3'd0, 0, 0, 5'd0, 0);
    check_eq("lb_req", dmem_req, 1);
    check_eq("lb_we", dmem_we, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("lb_stall", mem_stall, 1);
      check_eq("lb_addr_hold", dmem_addr, 32'h100);
      tick();
      check_eq("lb_no_wb", wb_valid, 0);
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'h80FF_FF7F;
    #1;
    check_eq("lb_ready_stall", mem_stall, 0);
    tick();
    check_eq("lb_wb_valid", wb_valid, 1);
    check_eq("lb_wb_data", wb_data, 32'hFFFF_FF80);
    check_eq("lb_wb_rd", wb_rd, 9);
    set_op(1, 1, 0, 3'd4, 32'h103, 0, 5'd9, 1);
    tick();
    set_op(0, 0, 0, 3'd0, 0, 0, 5'd0, 0);
    check_eq("lbu_req", dmem_req, 1);
    tick();
    check_eq("lbu_wb_data", wb_data, 32'h0000_0080);

    // SH to upper half
    dmem_ready = 1'b0;
    set_op(1, 0, 1, 3'd1, 32'h202, 32'hABCD_1234, 5'd7, 1);
    tick();
    set_op(0, 0, 0, 3'd0, 0, 0, 5'd0, 0);
    check_eq("sh_addr", dmem_addr, 32'h200);
    check_eq("sh_be", dmem_be, 4'b1100);
    check_eq("sh_wdata", dmem_wdata, 32'h1234_1234);
    check_eq("sh_we", dmem_we, 1);
    dmem_ready = 1'b1;
    tick();
    check_eq("sh_wb_valid", wb_valid, 1);
    check_eq("sh_wb_rw", wb_reg_write, 0);
    check_eq("sh_wb_data", wb_data, 32'h202);

    // misaligned LW
    set_op(1, 1, 0, 3'd2, 32'h106, 0, 5'd4, 1);
    tick();
    set_op(0, 0, 0, 3'd0, 0, 0, 5'd0, 0);
    check_eq("lwx_no_req", dmem_req, 0);
    check_eq("lwx_wb_valid", wb_valid, 1);
    check_eq("lwx_exc", mem_exc, 1);
    check_eq("lwx_rw", wb_reg_write, 0);

    // back-to-back LW / SW with ready held high
    set_op(1, 1, 0, 3'd2, 32'h100, 0, 5'd3, 1);
    #1;
    check_eq("b2b_stall0", mem_stall, 0);
    tick();
    check_eq("b2b_req0", dmem_req, 1);
    check_eq("b2b_addr0", dmem_addr, 32'h100);
    set_op(1, 0, 1, 3'd2, 32'h104, 32'hCAFE_F00D, 5'd8, 1);
    dmem_rdata = 32'h1122_3344;
    #1;
    check_eq("b2b_stall1", mem_stall, 0);
    tick();
    set_op(0, 0, 0, 3'd0, 0, 0, 5'd0, 0);
    check_eq("b2b_req1", dmem_req, 1);
    check_eq("b2b_addr1", dmem_addr, 32'h104);
    check_eq("b2b_we1", dmem_we, 1);
    check_eq("b2b_wdata1", dmem_wdata, 32'hCAFE_F00D);
    check_eq("b2b_wb1_valid", wb_valid, 1);
    check_eq("b2b_wb1_data", wb_data, 32'h1122_3344);
    check_eq("b2b_wb1_rd", wb_rd, 3);
    tick();
    check_eq("b2b_wb2_valid", wb_valid, 1);
    check_eq("b2b_wb2_data", wb_data, 32'h104);
    check_eq("b2b_wb2_rw", wb_reg_write, 0);
    check_eq("b2b_req_done", dmem_req, 0);
    tick();
    check_eq("idle_ready_ignored", wb_valid, 0);

    // reset in the middle of an access
    dmem_ready = 1'b0;
    set_op(1, 1, 0, 3'd2, 32'h100, 0, 5'd6, 1);
    tick();
    set_op(0, 0, 0, 3'd0, 0, 0, 5'd0, 0);
    check_eq("rstm_req_before", dmem_req, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rstm_req", dmem_req, 0);
    check_eq("rstm_stall", mem_stall, 0);
    check_eq("rstm_wb", wb_valid, 0);
    dmem_ready = 1'b1;
    @(negedge clk);
    check_eq("rstm_wb_held", wb_valid, 0);
    rst = 1'b0;
    set_op(1, 0, 0, 3'd0, 32'h0000_5A5A, 0, 5'd2, 1);
    tick();
    set_op(0, 0, 0, 3'd0, 0, 0, 5'd0, 0);
    check_eq("rstm_accept_wb", wb_valid, 1);
    check_eq("rstm_accept_data", wb_data, 32'h0000_5A5A);
    tick();

    for (int c = 0; c < 1500; c++) rand_cycle(0);
    for (int c = 0; c < 4; c++) rand_cycle(1);
    check_eq("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
